// File: rtl/wb_scheduler_pkg.sv
// Shared defaults and types for the writeback scheduler.
// Optional stall statistics are enabled with the WB_STALL_STATS_EN macro.
package wb_scheduler_pkg;

   localparam int unsigned DMEM_DATA_WIDTH    = 8;
   localparam int unsigned REG_ADDR_WIDTH     = 3;
   localparam int unsigned WB_MAX_OUTSTANDING = 4;
   localparam int unsigned STALL_CNT_WIDTH    = 16;

   // Source that owns the register-file write port in a given cycle.
   typedef enum logic [1:0] {
      WbNone,
      WbMem,
      WbAlu
   } wb_src_e;

endpackage

// File: rtl/wb_scheduler_if.sv
// Bus bundle between execute/memory stages and the writeback scheduler.
// The slave modport is the scheduler side; the master modport is the pipeline side.
interface wb_scheduler_if #(
   parameter int unsigned DATA_WIDTH     = wb_scheduler_pkg::DMEM_DATA_WIDTH,
   parameter int unsigned REG_ADDR_WIDTH = wb_scheduler_pkg::REG_ADDR_WIDTH
);
   localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;

   logic                      alu_valid;
   logic [REG_ADDR_WIDTH-1:0] alu_rd;
   logic [DATA_WIDTH-1:0]     alu_z;
   logic                      alu_ready;
   logic                      ld_issue;
   logic [REG_ADDR_WIDTH-1:0] ld_rd;
   logic                      ld_ready;
   logic                      mem_valid;
   logic [DATA_WIDTH-1:0]     mem_value;
   logic                      rf_we;
   logic [REG_ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0]     rf_wdata;
   logic [NumRegs-1:0]        busy;
   logic                      err;

   modport master (
      output alu_valid, alu_rd, alu_z, ld_issue, ld_rd, mem_valid, mem_value,
      input  alu_ready, ld_ready, rf_we, rf_waddr, rf_wdata, busy, err
   );

   modport slave (
      input  alu_valid, alu_rd, alu_z, ld_issue, ld_rd, mem_valid, mem_value,
      output alu_ready, ld_ready, rf_we, rf_waddr, rf_wdata, busy, err
   );

endinterface

// File: rtl/wb_tag_fifo.sv
// In-order FIFO of destination-register tags for loads in flight.
// Push and pop may occur in the same cycle; callers must not push when full without popping.
module wb_tag_fifo
   import wb_scheduler_pkg::*;
#(
   parameter int unsigned TAG_WIDTH  = wb_scheduler_pkg::REG_ADDR_WIDTH,
   parameter int unsigned DEPTH      = wb_scheduler_pkg::WB_MAX_OUTSTANDING,
   localparam int unsigned PtrWidth   = $clog2(DEPTH),
   localparam int unsigned CountWidth = PtrWidth + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [TAG_WIDTH-1:0]  din_i,
   output logic [TAG_WIDTH-1:0]  dout_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [CountWidth-1:0] count_o
);

   logic [TAG_WIDTH-1:0]  mem_q [DEPTH];
   logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CountWidth-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_i) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CountWidth'(1);
         2'b01:   count_d = count_q - CountWidth'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CountWidth'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/wb_scheduler.sv
// Arbitrates the single register-file write port between ALU results and load returns.
// Define WB_STALL_STATS_EN to add the saturating stall_cnt output.
module wb_scheduler
   import wb_scheduler_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = wb_scheduler_pkg::DMEM_DATA_WIDTH,
   parameter int unsigned REG_ADDR_WIDTH  = wb_scheduler_pkg::REG_ADDR_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = wb_scheduler_pkg::WB_MAX_OUTSTANDING
) (
   input  logic clk,
   input  logic rst,
   wb_scheduler_if.slave bus
`ifdef WB_STALL_STATS_EN
   ,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt
`endif
);

   localparam int unsigned NumRegs    = 2 ** REG_ADDR_WIDTH;
   localparam int unsigned CountWidth = $clog2(MAX_OUTSTANDING) + 1;

   logic                      fifo_full, fifo_empty;
   logic [CountWidth-1:0]     fifo_count;
   logic [REG_ADDR_WIDTH-1:0] head_tag;
   logic                      unused_count;

   logic                      mem_valid_eff, ld_ready, alu_ready, ld_accept;
   wb_src_e                   src;

   logic [NumRegs-1:0]        busy_q, busy_d;
   logic                      err_q, err_d;
   logic                      rf_we_q, rf_we_d;
   logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;

   wb_tag_fifo #(
      .TAG_WIDTH (REG_ADDR_WIDTH),
      .DEPTH     (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (ld_accept),
      .pop_i   (mem_valid_eff),
      .din_i   (bus.ld_rd),
      .dout_o  (head_tag),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign unused_count = ^fifo_count;

   // ld_ready looks at the pre-pop occupancy, so a full FIFO refuses even when popping.
   assign mem_valid_eff = bus.mem_valid & ~fifo_empty;
   assign ld_ready      = ~fifo_full & ~busy_q[bus.ld_rd];
   assign alu_ready     = ~mem_valid_eff & ~busy_q[bus.alu_rd];
   assign ld_accept     = bus.ld_issue & ld_ready;

   always_comb begin
      if (mem_valid_eff)                   src = WbMem;
      else if (bus.alu_valid && alu_ready) src = WbAlu;
      else                                 src = WbNone;
   end

   always_comb begin
      busy_d = busy_q;
      if (mem_valid_eff) busy_d[head_tag]   = 1'b0;
      if (ld_accept)     busy_d[bus.ld_rd] = 1'b1;
      err_d      = err_q | (bus.mem_valid & fifo_empty);
      rf_we_d    = (src != WbNone);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      unique case (src)
         WbMem: begin
            rf_waddr_d = head_tag;
            rf_wdata_d = bus.mem_value;
         end
         WbAlu: begin
            rf_waddr_d = bus.alu_rd;
            rf_wdata_d = bus.alu_z;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= '0;
         err_q      <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         busy_q     <= busy_d;
         err_q      <= err_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign bus.alu_ready = alu_ready;
   assign bus.ld_ready  = ld_ready;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

`ifdef WB_STALL_STATS_EN
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.alu_valid && !alu_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_scheduler.sv
// Scoreboard bench for wb_scheduler: expected writes are queued by the stimulus
// and checked by a monitor whenever rf_we is seen.
module tb_wb_scheduler;

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   int   tests  = 0;
   int   failed = 0;
   wr_t  sb[$];

   wb_scheduler_if bus_if ();

`ifdef WB_STALL_STATS_EN
   logic [15:0] stall_cnt;
`endif

   wb_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
`ifdef WB_STALL_STATS_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit av, input logic [2:0] ar, input logic [7:0] az,
                        input bit li, input logic [2:0] lr,
                        input bit mv, input logic [7:0] mval);
      bus_if.alu_valid = av;
      bus_if.alu_rd    = ar;
      bus_if.alu_z     = az;
      bus_if.ld_issue  = li;
      bus_if.ld_rd     = lr;
      bus_if.mem_valid = mv;
      bus_if.mem_value = mval;
   endtask

   task automatic idle();
      drive(0, 3'd0, 8'h00, 0, 3'd0, 0, 8'h00);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [2:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   // Monitor: every observed write must match the oldest expected write.
   always @(negedge clk) begin
      if (bus_if.rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_write: got r%0d=%0h expected no write at %0t",
                     bus_if.rf_waddr, bus_if.rf_wdata, $time);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("rf_write", {21'd0, bus_if.rf_waddr, bus_if.rf_wdata}, {21'd0, e.addr, e.data});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rf_we", 32'(bus_if.rf_we), 32'd0);
      chk("reset_rf_waddr", 32'(bus_if.rf_waddr), 32'd0);
      chk("reset_rf_wdata", 32'(bus_if.rf_wdata), 32'd0);
      chk("reset_busy", 32'(bus_if.busy), 32'd0);
      chk("reset_err", 32'(bus_if.err), 32'd0);
`ifdef WB_STALL_STATS_EN
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      rst = 1'b0;
      next_cycle();

      // ALU only
      drive(1, 3'd2, 8'h5A, 0, 3'd0, 0, 8'h00);
      expect_wr(3'd2, 8'h5A);
      @(negedge clk); chk("alu_only_ready", 32'(bus_if.alu_ready), 32'd1);
      next_cycle(); idle(); next_cycle();

      // Load round trip
      drive(0, 3'd0, 8'h00, 1, 3'd3, 0, 8'h00);
      @(negedge clk); chk("ld_rt_ready", 32'(bus_if.ld_ready), 32'd1);
      next_cycle(); idle();
      @(negedge clk); chk("ld_rt_busy", 32'(bus_if.busy), 32'h08);
      next_cycle(); next_cycle();
      drive(0, 3'd0, 8'h00, 0, 3'd0, 1, 8'hC3);
      expect_wr(3'd3, 8'hC3);
      next_cycle(); idle();
      @(negedge clk); chk("ld_rt_busy_clear", 32'(bus_if.busy), 32'h00);
      next_cycle();

      // Conflict: memory response wins the port
      drive(0, 3'd0, 8'h00, 1, 3'd4, 0, 8'h00);
      next_cycle(); idle(); next_cycle();
      drive(1, 3'd1, 8'h11, 0, 3'd0, 1, 8'h22);
      expect_wr(3'd4, 8'h22);
      @(negedge clk); chk("conflict_alu_stall", 32'(bus_if.alu_ready), 32'd0);
      next_cycle();
      drive(1, 3'd1, 8'h11, 0, 3'd0, 0, 8'h00);
      expect_wr(3'd1, 8'h11);
      @(negedge clk); chk("conflict_alu_accept", 32'(bus_if.alu_ready), 32'd1);
      next_cycle(); idle(); next_cycle();

      // WAW stall against a pending load
      drive(0, 3'd0, 8'h00, 1, 3'd5, 0, 8'h00);
      next_cycle();
      drive(1, 3'd5, 8'h55, 0, 3'd0, 0, 8'h00);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); chk("waw_stall", 32'(bus_if.alu_ready), 32'd0);
         next_cycle();
      end
      drive(1, 3'd5, 8'h55, 0, 3'd0, 1, 8'h77);
      expect_wr(3'd5, 8'h77);
      @(negedge clk); chk("waw_resp_stall", 32'(bus_if.alu_ready), 32'd0);
      next_cycle();
      drive(1, 3'd5, 8'h55, 0, 3'd0, 0, 8'h00);
      expect_wr(3'd5, 8'h55);
      @(negedge clk); chk("waw_accept", 32'(bus_if.alu_ready), 32'd1);
      next_cycle(); idle(); next_cycle();

      // Fill the FIFO with loads to r0..r3
      for (int i = 0; i < 4; i++) begin
         drive(0, 3'd0, 8'h00, 1, 3'(i), 0, 8'h00);
         @(negedge clk); chk("fill_ready", 32'(bus_if.ld_ready), 32'd1);
         next_cycle();
      end
      drive(0, 3'd0, 8'h00, 1, 3'd6, 0, 8'h00);
      @(negedge clk);
      chk("full_refuse", 32'(bus_if.ld_ready), 32'd0);
      chk("full_busy", 32'(bus_if.busy), 32'h0F);
      next_cycle();
      // Push+pop while full is still refused
      drive(0, 3'd0, 8'h00, 1, 3'd6, 1, 8'hA0);
      expect_wr(3'd0, 8'hA0);
      @(negedge clk); chk("full_pushpop_refuse", 32'(bus_if.ld_ready), 32'd0);
      next_cycle();
      // At count 3 push+pop is accepted and count stays 3
      drive(0, 3'd0, 8'h00, 1, 3'd6, 1, 8'hA1);
      expect_wr(3'd1, 8'hA1);
      @(negedge clk); chk("cnt3_pushpop_accept", 32'(bus_if.ld_ready), 32'd1);
      next_cycle(); idle();
      @(negedge clk); chk("cnt3_busy", 32'(bus_if.busy), 32'h4C);
      next_cycle();
      drive(0, 3'd0, 8'h00, 1, 3'd7, 0, 8'h00);
      @(negedge clk); chk("cnt3_fill_accept", 32'(bus_if.ld_ready), 32'd1);
      next_cycle();
      drive(0, 3'd0, 8'h00, 1, 3'd0, 0, 8'h00);
      @(negedge clk); chk("cnt4_refuse", 32'(bus_if.ld_ready), 32'd0);
      next_cycle();
      drive(0, 3'd0, 8'h00, 0, 3'd0, 1, 8'hA2); expect_wr(3'd2, 8'hA2); next_cycle();
      drive(0, 3'd0, 8'h00, 0, 3'd0, 1, 8'hA3); expect_wr(3'd3, 8'hA3); next_cycle();
      drive(0, 3'd0, 8'h00, 0, 3'd0, 1, 8'hA6); expect_wr(3'd6, 8'hA6); next_cycle();
      drive(0, 3'd0, 8'h00, 0, 3'd0, 1, 8'hA7); expect_wr(3'd7, 8'hA7); next_cycle();
      idle();
      @(negedge clk); chk("drain_busy", 32'(bus_if.busy), 32'h00);
      next_cycle();

      // Same-cycle ALU accept and load issue to the same register
      drive(1, 3'd7, 8'h70, 1, 3'd7, 0, 8'h00);
      expect_wr(3'd7, 8'h70);
      @(negedge clk);
      chk("same_rd_alu_ready", 32'(bus_if.alu_ready), 32'd1);
      chk("same_rd_ld_ready", 32'(bus_if.ld_ready), 32'd1);
      next_cycle(); idle(); next_cycle();
      drive(0, 3'd0, 8'h00, 0, 3'd0, 1, 8'h7F);
      expect_wr(3'd7, 8'h7F);
      next_cycle(); idle(); next_cycle();

      // Spurious response with an empty FIFO
      chk("pre_spurious_err", 32'(bus_if.err), 32'd0);
      drive(0, 3'd0, 8'h00, 0, 3'd0, 1, 8'hEE);
      next_cycle(); idle();
      @(negedge clk); chk("spurious_err", 32'(bus_if.err), 32'd1);
      repeat (3) next_cycle();
      @(negedge clk); chk("spurious_err_sticky", 32'(bus_if.err), 32'd1);
      next_cycle();

      // Reset mid-flight
      drive(0, 3'd0, 8'h00, 1, 3'd2, 0, 8'h00); next_cycle();
      drive(0, 3'd0, 8'h00, 1, 3'd5, 0, 8'h00); next_cycle();
      idle();
      @(negedge clk); chk("midflight_busy", 32'(bus_if.busy), 32'h24);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("midflight_rst_busy", 32'(bus_if.busy), 32'h00);
      chk("midflight_rst_err", 32'(bus_if.err), 32'd0);
      next_cycle();
      drive(0, 3'd0, 8'h00, 0, 3'd0, 1, 8'h99);
      next_cycle(); idle();
      @(negedge clk); chk("late_resp_err", 32'(bus_if.err), 32'd1);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk); chk("rst_clears_err", 32'(bus_if.err), 32'd0);
      next_cycle();

      // Seven stall cycles on a WAW hazard
      drive(0, 3'd0, 8'h00, 1, 3'd1, 0, 8'h00); next_cycle();
      drive(1, 3'd1, 8'h31, 0, 3'd0, 0, 8'h00);
      for (int i = 0; i < 7; i++) next_cycle();
      idle();
      @(negedge clk);
`ifdef WB_STALL_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'd7);
`endif
      chk("stall_busy", 32'(bus_if.busy), 32'h02);
      next_cycle();
      drive(0, 3'd0, 8'h00, 0, 3'd0, 1, 8'h13); expect_wr(3'd1, 8'h13); next_cycle();
      drive(1, 3'd1, 8'h31, 0, 3'd0, 0, 8'h00); expect_wr(3'd1, 8'h31);
      @(negedge clk); chk("stall_release", 32'(bus_if.alu_ready), 32'd1);
      next_cycle(); idle();
      repeat (3) next_cycle();

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
